// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   fc_state_e   : fetch FSM state encoding (2 bits)
//   INST_BYTES   : PC increment per instruction
//   FC_RESET_PC  : default PC loaded at reset
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,   // out of reset, no request yet
        FC_REQ  = 2'd1,   // request outstanding to instruction memory
        FC_HOLD = 2'd2    // response parked in skid buffer while stalled
    } fc_state_e;

    localparam int          INST_BYTES  = 4;
    localparam logic [63:0] FC_RESET_PC = 64'h0;

endpackage

// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// dff
// Generic enabled register with asynchronous active-low reset.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, loads RST_VAL
//   en     : load enable
//   d      : next value
//   q      : registered value
// ---------------------------------------------------------------------------
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= RST_VAL;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// One-entry buffer holding an instruction and its PC when a memory response
// arrives while the pipeline is stalled.
//   clk, rst_n : clock / asynchronous active-low reset
//   load       : capture load_inst/load_pc, mark entry valid
//   drain      : entry consumed, mark invalid
//   clear      : discard entry (redirect); wins over load and drain
//   valid      : entry holds a response
//   inst, pc   : buffered instruction and its PC
// ---------------------------------------------------------------------------
module fetch_skid
    import fetch_ctrl_pkg::*;
#(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 drain,
    input  logic                 clear,
    input  logic [INST_SIZE-1:0] load_inst,
    input  logic [WORD-1:0]      load_pc,
    output logic                 valid,
    output logic [INST_SIZE-1:0] inst,
    output logic [WORD-1:0]      pc
);

    logic                 valid_reg;
    logic [INST_SIZE-1:0] inst_reg;
    logic [WORD-1:0]      pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            inst_reg  <= '0;
            pc_reg    <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            inst_reg  <= load_inst;
            pc_reg    <= load_pc;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign inst  = inst_reg;
    assign pc    = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch stage sequencer: owns the PC, selects next PC
// (sequential / branch / register jump), runs a req/ready handshake to a
// variable-latency instruction memory and drives the IF/ID register.
//
// Ports:
//   clk, rst_n            : clock / asynchronous active-low reset
//   stall                 : hold IF/ID and PC
//   br_taken, br_target   : EX branch redirect
//   jr_taken, jr_target   : EX register-jump redirect (beats branch)
//   imem_req, imem_addr   : fetch request / address (combinational from state)
//   imem_ready, imem_inst : memory response
//   if_valid, if_pc,
//   if_pc_incr, if_inst   : IF/ID register (registered)
//   flush                 : one-cycle squash pulse, same cycle as redirect
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int            WORD      = 64,
    parameter int            INST_SIZE = 32,
    parameter logic [WORD-1:0] RESET_PC = WORD'(FC_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [WORD-1:0]      br_target,
    input  logic                 jr_taken,
    input  logic [WORD-1:0]      jr_target,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ready,
    input  logic [INST_SIZE-1:0] imem_inst,
    output logic                 if_valid,
    output logic [WORD-1:0]      if_pc,
    output logic [WORD-1:0]      if_pc_incr,
    output logic [INST_SIZE-1:0] if_inst,
    output logic                 flush
);

    localparam logic [WORD-1:0] PC_STEP = WORD'(INST_BYTES);

    fc_state_e            state_reg;
    logic                 kill_reg;       // outstanding request belongs to a squashed path
    logic [WORD-1:0]      kill_addr_reg;  // address of that request, held until ready
    logic                 if_valid_reg;
    logic [WORD-1:0]      if_pc_reg;
    logic [WORD-1:0]      if_pc_incr_reg;
    logic [INST_SIZE-1:0] if_inst_reg;

    logic [WORD-1:0]      pc_q;
    logic [WORD-1:0]      pc_next;
    logic                 pc_en;
    logic [WORD-1:0]      pc_incr;

    logic                 redirect;
    logic [WORD-1:0]      redirect_target;
    logic                 accept;
    logic                 take_live;
    logic                 hold_release;

    logic                 skid_load;
    logic                 skid_valid;
    logic [INST_SIZE-1:0] skid_inst;
    logic [WORD-1:0]      skid_pc;

    // ---------------------------------------------------------------------
    // Next-PC selection and handshake decode
    // ---------------------------------------------------------------------
    always_comb begin
        redirect        = (state_reg != FC_IDLE) && (jr_taken || br_taken);
        redirect_target = jr_taken ? jr_target : br_target;
        accept          = (state_reg == FC_REQ) && imem_ready;
        // A response is live only if it is not the tail of a squashed path
        // and no redirect squashes it in the same cycle.
        take_live       = accept && !kill_reg && !redirect;
        hold_release    = (state_reg == FC_HOLD) && !stall && !redirect;
        skid_load       = take_live && stall;
        pc_incr         = pc_q + PC_STEP;   // wraps modulo 2^WORD

        pc_en   = 1'b0;
        pc_next = pc_incr;
        if (redirect) begin
            pc_en   = 1'b1;
            pc_next = redirect_target;
        end else if (take_live && !stall) begin
            pc_en   = 1'b1;
        end else if (hold_release && skid_valid) begin
            // PC still points at the buffered instruction; advance now that
            // it has moved into IF/ID.
            pc_en   = 1'b1;
        end
    end

    dff #(
        .W       (WORD),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_next),
        .q     (pc_q)
    );

    fetch_skid #(
        .WORD      (WORD),
        .INST_SIZE (INST_SIZE)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (hold_release),
        .clear     (redirect),
        .load_inst (imem_inst),
        .load_pc   (pc_q),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );

    // ---------------------------------------------------------------------
    // Fetch FSM and IF/ID register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FC_IDLE;
            kill_reg       <= 1'b0;
            kill_addr_reg  <= '0;
            if_valid_reg   <= 1'b0;
            if_pc_reg      <= '0;
            if_pc_incr_reg <= '0;
            if_inst_reg    <= '0;
        end else begin
            case (state_reg)
                FC_IDLE: begin
                    state_reg <= FC_REQ;
                end

                FC_REQ: begin
                    if (redirect) begin
                        if_valid_reg <= 1'b0;
                        if (!imem_ready) begin
                            // Let the in-flight request finish at its own
                            // address; keep the first squashed address if
                            // redirects stack up.
                            kill_reg <= 1'b1;
                            if (!kill_reg) begin
                                kill_addr_reg <= pc_q;
                            end
                        end else begin
                            kill_reg <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        kill_reg <= 1'b0;
                        if (kill_reg) begin
                            // Squashed response: drop it, bubble if ID advances.
                            if (!stall) begin
                                if_valid_reg <= 1'b0;
                            end
                        end else if (stall) begin
                            state_reg <= FC_HOLD;
                        end else begin
                            if_valid_reg   <= 1'b1;
                            if_pc_reg      <= pc_q;
                            if_pc_incr_reg <= pc_incr;
                            if_inst_reg    <= imem_inst;
                        end
                    end else if (!stall) begin
                        // ID consumed the previous instruction; nothing new yet.
                        if_valid_reg <= 1'b0;
                    end
                end

                FC_HOLD: begin
                    if (redirect) begin
                        if_valid_reg <= 1'b0;
                        state_reg    <= FC_REQ;
                    end else if (!stall) begin
                        if (skid_valid) begin
                            if_valid_reg   <= 1'b1;
                            if_pc_reg      <= skid_pc;
                            if_pc_incr_reg <= skid_pc + PC_STEP;
                            if_inst_reg    <= skid_inst;
                        end
                        state_reg <= FC_REQ;
                    end
                end

                default: begin
                    state_reg <= FC_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = (state_reg == FC_REQ);
    assign imem_addr  = kill_reg ? kill_addr_reg : pc_q;
    assign flush      = redirect;
    assign if_valid   = if_valid_reg;
    assign if_pc      = if_pc_reg;
    assign if_pc_incr = if_pc_incr_reg;
    assign if_inst    = if_inst_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl: a table of per-cycle vectors for the
// zero-wait / stall / redirect / wrap flow, plus hand-written sequences for
// multi-cycle memory latency, killed requests and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int          WORD      = 64;
    localparam int          INST_SIZE = 32;
    localparam logic [63:0] WRAP_PC   = 64'hFFFF_FFFF_FFFF_FFFC;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stall = 1'b0;
    logic                 br_taken = 1'b0;
    logic [WORD-1:0]      br_target = '0;
    logic                 jr_taken = 1'b0;
    logic [WORD-1:0]      jr_target = '0;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ready = 1'b0;
    logic [INST_SIZE-1:0] imem_inst = '0;
    logic                 if_valid;
    logic [WORD-1:0]      if_pc;
    logic [WORD-1:0]      if_pc_incr;
    logic [INST_SIZE-1:0] if_inst;
    logic                 flush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .WORD      (WORD),
        .INST_SIZE (INST_SIZE),
        .RESET_PC  (64'h0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jr_taken   (jr_taken),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_inst  (imem_inst),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_pc_incr (if_pc_incr),
        .if_inst    (if_inst),
        .flush      (flush)
    );

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory model: each request takes mem_lat cycles (1 = zero-wait).
    int mem_lat = 1;
    int mem_cnt = 0;

    always @(negedge clk) begin
        imem_ready = imem_req && (mem_cnt >= mem_lat - 1);
        imem_inst  = inst_of(imem_addr);
    end

    always @(posedge clk) begin
        if (!rst_n)                     mem_cnt <= 0;
        else if (imem_req && imem_ready) mem_cnt <= 0;
        else if (imem_req)              mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".imem_req"},   64'(imem_req),   64'h0);
        chk({tag, ".imem_addr"},  imem_addr,       64'h0);
        chk({tag, ".if_valid"},   64'(if_valid),   64'h0);
        chk({tag, ".if_pc"},      if_pc,           64'h0);
        chk({tag, ".if_pc_incr"}, if_pc_incr,      64'h0);
        chk({tag, ".if_inst"},    64'(if_inst),    64'h0);
        chk({tag, ".flush"},      64'(flush),      64'h0);
    endtask

    task automatic clear_inputs();
        stall = 1'b0; br_taken = 1'b0; br_target = '0;
        jr_taken = 1'b0; jr_target = '0;
    endtask

    // Hold reset a few cycles, release at a falling edge.
    task automatic do_reset(input int lat);
        rst_n = 1'b0;
        clear_inputs();
        mem_lat = lat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] bt;
        logic        jr;
        logic [63:0] jt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_flush;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic s, input logic b, input logic [63:0] bt,
                                input logic j, input logic [63:0] jt,
                                input logic rq, input logic [63:0] ad,
                                input logic fl, input logic v, input logic [63:0] pc);
        vec_t r;
        r.stall = s; r.br = b; r.bt = bt; r.jr = j; r.jt = jt;
        r.e_req = rq; r.e_addr = ad; r.e_flush = fl; r.e_valid = v; r.e_pc = pc;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [63:0] exp_pc;

        // ------------------------------------------------------------------
        // Reset state
        // ------------------------------------------------------------------
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk_all_zero("reset");

        // ------------------------------------------------------------------
        // Table: zero-wait fetch, stall over response 0x10, jr+br+stall,
        // wrap at top of address space. One row per cycle, row 0 is the
        // cycle in which reset is released.
        //           stall br bt        jr jt      req addr     fl v  if_pc
        vt[0]  = mk(0, 0, 0,        0, 0,      0, 64'h0,    0, 0, 64'h0);
        vt[1]  = mk(0, 0, 0,        0, 0,      1, 64'h0,    0, 0, 64'h0);
        vt[2]  = mk(0, 0, 0,        0, 0,      1, 64'h4,    0, 1, 64'h0);
        vt[3]  = mk(0, 0, 0,        0, 0,      1, 64'h8,    0, 1, 64'h4);
        vt[4]  = mk(0, 0, 0,        0, 0,      1, 64'hC,    0, 1, 64'h8);
        vt[5]  = mk(1, 0, 0,        0, 0,      1, 64'h10,   0, 1, 64'hC);
        vt[6]  = mk(1, 0, 0,        0, 0,      0, 64'h10,   0, 1, 64'hC);
        vt[7]  = mk(1, 0, 0,        0, 0,      0, 64'h10,   0, 1, 64'hC);
        vt[8]  = mk(1, 0, 0,        0, 0,      0, 64'h10,   0, 1, 64'hC);
        vt[9]  = mk(0, 0, 0,        0, 0,      0, 64'h10,   0, 1, 64'hC);
        vt[10] = mk(0, 0, 0,        0, 0,      1, 64'h14,   0, 1, 64'h10);
        vt[11] = mk(0, 0, 0,        0, 0,      1, 64'h18,   0, 1, 64'h14);
        vt[12] = mk(1, 1, 64'h200,  1, 64'h400, 1, 64'h1C,  1, 1, 64'h18);
        vt[13] = mk(0, 0, 0,        0, 0,      1, 64'h400,  0, 0, 64'h0);
        vt[14] = mk(0, 1, WRAP_PC,  0, 0,      1, 64'h404,  1, 1, 64'h400);
        vt[15] = mk(0, 0, 0,        0, 0,      1, WRAP_PC,  0, 0, 64'h0);
        vt[16] = mk(0, 0, 0,        0, 0,      1, 64'h0,    0, 1, WRAP_PC);
        vt[17] = mk(0, 0, 0,        0, 0,      1, 64'h4,    0, 1, 64'h0);

        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            stall = vt[i].stall; br_taken = vt[i].br; br_target = vt[i].bt;
            jr_taken = vt[i].jr; jr_target = vt[i].jt;
            #1;
            $display("row %0d: req=%b addr=%h flush=%b valid=%b if_pc=%h",
                     i, imem_req, imem_addr, flush, if_valid, if_pc);
            chk($sformatf("row%0d.imem_req", i),  64'(imem_req), 64'(vt[i].e_req));
            chk($sformatf("row%0d.imem_addr", i), imem_addr,     vt[i].e_addr);
            chk($sformatf("row%0d.flush", i),     64'(flush),    64'(vt[i].e_flush));
            chk($sformatf("row%0d.if_valid", i),  64'(if_valid), 64'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("row%0d.if_pc", i),      if_pc,          vt[i].e_pc);
                chk($sformatf("row%0d.if_pc_incr", i), if_pc_incr,     vt[i].e_pc + 64'd4);
                chk($sformatf("row%0d.if_inst", i),    64'(if_inst),   64'(inst_of(vt[i].e_pc)));
            end
        end
        clear_inputs();

        // ------------------------------------------------------------------
        // 3-cycle memory: each address held 3 cycles, IF/ID updated once per
        // 3 cycles with consecutive PCs.
        // ------------------------------------------------------------------
        do_reset(3);
        @(negedge clk); // leave IDLE
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                #1;
                exp_pc = 64'(4 * k);
                $display("lat3 k=%0d j=%0d: addr=%h if_pc=%h valid=%b", k, j, imem_addr, if_pc, if_valid);
                chk($sformatf("lat3.addr k%0d j%0d", k, j), imem_addr, exp_pc);
                chk($sformatf("lat3.req k%0d j%0d", k, j), 64'(imem_req), 64'h1);
                if (k > 0) begin
                    chk($sformatf("lat3.if_pc k%0d j%0d", k, j), if_pc, exp_pc - 64'd4);
                    chk($sformatf("lat3.if_inst k%0d j%0d", k, j), 64'(if_inst),
                        64'(inst_of(exp_pc - 64'd4)));
                end
                @(negedge clk);
            end
        end

        // ------------------------------------------------------------------
        // Branch while request to 0x20 is pending, 2 cycles from ready.
        // ------------------------------------------------------------------
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            #1;
            if (imem_req && imem_addr == 64'h20) found = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL kill.find: request to 0x20 not seen, expected within 60 cycles");
        end else begin
            br_taken = 1'b1; br_target = 64'h100;
            #1;
            $display("kill redirect: addr=%h flush=%b if_pc=%h", imem_addr, flush, if_pc);
            chk("kill.flush_on", 64'(flush), 64'h1);
            chk("kill.prev_if_pc", if_pc, 64'h1C);
            @(negedge clk); clear_inputs(); #1;
            $display("kill wait1: addr=%h flush=%b valid=%b", imem_addr, flush, if_valid);
            chk("kill.flush_off", 64'(flush), 64'h0);
            chk("kill.if_valid0", 64'(if_valid), 64'h0);
            chk("kill.addr_held1", imem_addr, 64'h20);
            chk("kill.req_held1", 64'(imem_req), 64'h1);
            @(negedge clk); #1;
            $display("kill wait2: addr=%h ready=%b", imem_addr, imem_ready);
            chk("kill.addr_held2", imem_addr, 64'h20);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk); #1;
                $display("kill target j=%0d: addr=%h valid=%b", j, imem_addr, if_valid);
                chk($sformatf("kill.target_addr j%0d", j), imem_addr, 64'h100);
                chk($sformatf("kill.discarded j%0d", j), 64'(if_valid), 64'h0);
            end
            @(negedge clk); #1;
            $display("kill done: if_pc=%h valid=%b", if_pc, if_valid);
            chk("kill.if_valid1", 64'(if_valid), 64'h1);
            chk("kill.if_pc", if_pc, 64'h100);
            chk("kill.if_inst", 64'(if_inst), 64'(inst_of(64'h100)));
        end

        // ------------------------------------------------------------------
        // Asynchronous reset in the middle of a wait.
        // ------------------------------------------------------------------
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: req=%b addr=%h valid=%b if_pc=%h", imem_req, imem_addr, if_valid, if_pc);
        chk_all_zero("areset");
        mem_lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.idle_req", 64'(imem_req), 64'h0);
        @(negedge clk); #1;
        $display("release: req=%b addr=%h", imem_req, imem_addr);
        chk("rel.first_req", 64'(imem_req), 64'h1);
        chk("rel.first_addr", imem_addr, 64'h0);
        @(negedge clk); #1;
        $display("release+1: addr=%h if_pc=%h valid=%b", imem_addr, if_pc, if_valid);
        chk("rel.if_valid", 64'(if_valid), 64'h1);
        chk("rel.if_pc", if_pc, 64'h0);
        chk("rel.next_addr", imem_addr, 64'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
